// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge from the fetch stage's sram-like req/addr_ok/data_ok
// port to single-beat AXI4 reads. Only the AR and R channels are used.
// At most one AR is pending at a time. Accepted-but-unanswered reads are
// bounded by MAX_OUTSTANDING. Responses are assumed to be in order (single ID).
//
// Handshake semantics: an AXI transfer occurs on a rising edge where
// valid & ready are both 1. The valid side holds its payload stable until that
// edge. rready is tied high, so every R beat is consumed in the cycle it is
// presented. On the sram side, addr_ok is the same-cycle accept of req.
// data_ok flags the single cycle in which rdata is valid.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID            = 4'd0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_axi_err
);

  localparam logic [2:0] LP_MAX = 3'(MAX_OUTSTANDING);

  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [2:0]  r_cnt;
  logic        r_err;

  logic        w_accept;
  logic        w_beat;
  logic        w_dec;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic        w_unused;

  // Accept only when no AR is pending and the outstanding window has room.
  // Gating with resetn keeps addr_ok/data_ok low while reset is held.
  assign w_accept = resetn & inst_sram_req & ~inst_sram_wr & ~r_arvalid & (r_cnt < LP_MAX);
  // A counted beat answers an accepted request. Beats seen with cnt=0 are strays
  // (e.g. left over from before a reset). They are consumed and dropped.
  assign w_beat   = resetn & rvalid & (r_cnt != 3'd0);
  assign w_dec    = w_beat & rlast;

  // Normalise size (3 behaves as word) and word-align word addresses.
  always_comb begin
    w_size = inst_sram_size;
    if (inst_sram_size == 2'd3) w_size = 2'd2;
    w_addr = inst_sram_addr;
    if (w_size == 2'd2) w_addr[1:0] = 2'b00;
  end

  // AR register: load on accept, hold until the AR handshake completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_arvalid <= 1'b0;
      r_araddr  <= 32'd0;
      r_arsize  <= 3'd0;
    end else if (w_accept) begin
      r_arvalid <= 1'b1;
      r_araddr  <= w_addr;
      r_arsize  <= {1'b0, w_size};
    end else if (r_arvalid && arready) begin
      r_arvalid <= 1'b0;
    end
  end

  // Outstanding counter: accept and return in one cycle cancel each other out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 3'd0;
    end else begin
      case ({w_accept, w_dec})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky error flag: set by any counted beat with a non-OKAY response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_beat && (rresp != 2'b00)) begin
      r_err <= 1'b1;
    end
  end

  // Write-side inputs and rid carry no information for an in-order read bridge.
  assign w_unused = ^{inst_sram_wstrb, inst_sram_wdata, rid};

  assign inst_sram_addr_ok = w_accept;
  assign inst_sram_data_ok = w_beat;
  assign inst_sram_rdata   = rdata;

  assign arid    = ARID;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = r_arvalid;
  assign rready  = 1'b1;
  assign inst_axi_err = r_err;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge. It models a simple AXI slave
// whose memory content is a function of the address. An expected-data queue is
// filled on each accept and drained on each data_ok.
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        axi_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];     // expected data, in acceptance order
  logic [31:0] ar_exp_q[$];  // expected AR addresses, in acceptance order
  logic [31:0] slave_q[$];   // addresses handshaken on AR, awaiting an R beat

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .inst_axi_err(axi_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Slave memory content
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_BFC0;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] s);
    if (s >= 2'd2) return {a[31:2], 2'b00};
    return a;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic r_beat(input logic [1:0] resp);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rresp  = resp;
    rid    = 4'd0;
    if (slave_q.size() > 0) rdata = mem_fn(slave_q.pop_front());
    else                    rdata = 32'hDEAD_BEEF;
  endtask

  task automatic r_idle();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'd0;
    rdata  = 32'd0;
  endtask

  // Scoreboard monitor: push on accept, check AR address and returned data
  always @(negedge clk) begin
    logic [31:0] a;
    logic [31:0] e;
    if (resetn) begin
      if (addr_ok) begin
        a = align(addr, size);
        exp_q.push_back(mem_fn(a));
        ar_exp_q.push_back(a);
      end
      if (arvalid && arready) begin
        n_tests++;
        if (ar_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ar_unexpected: got araddr=%h, required no AR handshake", araddr);
        end else begin
          e = ar_exp_q.pop_front();
          if (araddr !== e) begin
            n_fail++;
            $display("FAIL ar_addr: got %h, required %h", araddr, e);
          end
        end
        slave_q.push_back(araddr);
      end
      if (data_ok) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL data_unexpected: got data_ok with rdata=%h, required none", sram_rdata);
        end else begin
          e = exp_q.pop_front();
          if (sram_rdata !== e) begin
            n_fail++;
            $display("FAIL data_order: got %h, required %h", sram_rdata, e);
          end
        end
      end
    end
  end

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending data_ok, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    req = 1'b1; addr = 32'h1234_5678; size = 2'd2;
    rvalid = 1'b1; rlast = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({arvalid, araddr, arsize, addr_ok, data_ok, rready, axi_err} !== {1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got arvalid=%b araddr=%h arsize=%0d addr_ok=%b data_ok=%b rready=%b err=%b, required 0,0,0,0,0,1,0",
               arvalid, araddr, arsize, addr_ok, data_ok, rready, axi_err);
    end
    n_tests++;
    if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL fixed_fields: got arid=%h arlen=%h arburst=%b arlock=%b arcache=%h arprot=%h, required 0,0,01,0,0,0",
               arid, arlen, arburst, arlock, arcache, arprot);
    end
    req = 1'b0;
    r_idle();
    #2 resetn = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick(); req = 1'b1; addr = 32'hBFC0_0000; size = 2'd2;
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL single_addr_ok: got %b, required 1", addr_ok); end
    tick(); req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({arvalid, araddr, arsize, arlen} !== {1'b1, 32'hBFC0_0000, 3'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL single_ar: got arvalid=%b araddr=%h arsize=%0d arlen=%0d, required 1,bfc00000,2,0", arvalid, araddr, arsize, arlen);
    end
    tick(); arready = 1'b1;
    @(negedge clk);
    tick(); arready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b0) begin n_fail++; $display("FAIL single_ar_drop: got arvalid=%b, required 0", arvalid); end
    tick(); r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if ({data_ok, sram_rdata} !== {1'b1, 32'h3C1D_BFC0}) begin
      n_fail++;
      $display("FAIL single_data: got data_ok=%b rdata=%h, required 1,3c1dbfc0", data_ok, sram_rdata);
    end
    tick(); r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if (data_ok !== 1'b0) begin n_fail++; $display("FAIL single_cnt_zero: got data_ok=%b, required 0", data_ok); end
    tick(); r_idle();
    check_drained("single");
  endtask

  task automatic test_sizes();
    logic [31:0] t_addr[4]  = '{32'h3000_0003, 32'h3000_0006, 32'h3000_0007, 32'h3000_000B};
    logic [1:0]  t_size[4]  = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] t_eaddr[4] = '{32'h3000_0003, 32'h3000_0006, 32'h3000_0004, 32'h3000_0008};
    logic [2:0]  t_esize[4] = '{3'd0, 3'd1, 3'd2, 3'd2};
    for (int i = 0; i < 4; i++) begin
      tick(); req = 1'b1; addr = t_addr[i]; size = t_size[i];
      @(negedge clk);
      n_tests++;
      if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL size%0d_addr_ok: got %b, required 1", i, addr_ok); end
      tick(); req = 1'b0; arready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({araddr, arsize} !== {t_eaddr[i], t_esize[i]}) begin
        n_fail++;
        $display("FAIL size%0d_ar: got araddr=%h arsize=%0d, required %h,%0d", i, araddr, arsize, t_eaddr[i], t_esize[i]);
      end
      tick(); arready = 1'b0; r_beat(2'b00);
      @(negedge clk);
      n_tests++;
      if (data_ok !== 1'b1) begin n_fail++; $display("FAIL size%0d_data_ok: got %b, required 1", i, data_ok); end
      tick(); r_idle();
    end
    check_drained("sizes");
  endtask

  task automatic test_backpressure();
    tick(); req = 1'b1; addr = 32'h1000_0010; size = 2'd2; arready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept: got %b, required 1", addr_ok); end
    tick(); addr = 32'h1000_0020;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({arvalid, araddr, addr_ok} !== {1'b1, 32'h1000_0010, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got arvalid=%b araddr=%h addr_ok=%b, required 1,10000010,0", i, arvalid, araddr, addr_ok);
      end
      tick();
    end
    arready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({arvalid, addr_ok} !== 2'b10) begin n_fail++; $display("FAIL bp_handshake: got arvalid=%b addr_ok=%b, required 1,0", arvalid, addr_ok); end
    tick(); arready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: got %b, required 1", addr_ok); end
    tick(); req = 1'b0; arready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({arvalid, araddr} !== {1'b1, 32'h1000_0020}) begin
      n_fail++;
      $display("FAIL bp_second_ar: got arvalid=%b araddr=%h, required 1,10000020", arvalid, araddr);
    end
    tick(); arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_beat(2'b00);
      @(negedge clk);
      tick(); r_idle();
    end
    check_drained("bp");
  endtask

  task automatic test_full();
    arready = 1'b1;
    tick(); req = 1'b1; addr = 32'h2000_0000; size = 2'd2;
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_accept0: got %b, required 1", addr_ok); end
    tick(); addr = 32'h2000_0004;
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_ar_pending: got addr_ok=%b, required 0", addr_ok); end
    tick();
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_accept1: got %b, required 1", addr_ok); end
    tick(); addr = 32'h2000_0008;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_blocked%0d: got addr_ok=%b, required 0", i, addr_ok); end
    end
    tick(); r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if ({addr_ok, data_ok} !== 2'b01) begin n_fail++; $display("FAIL full_return: got addr_ok=%b data_ok=%b, required 0,1", addr_ok, data_ok); end
    tick(); r_idle();
    @(negedge clk);
    n_tests++;
    if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_reaccept: got %b, required 1", addr_ok); end
    tick(); req = 1'b0;
    @(negedge clk);
    tick(); arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_beat(2'b00);
      @(negedge clk);
      n_tests++;
      if (data_ok !== 1'b1) begin n_fail++; $display("FAIL full_drain%0d: got data_ok=%b, required 1", i, data_ok); end
      tick(); r_idle();
    end
    check_drained("full");
  endtask

  task automatic test_simultaneous();
    tick(); req = 1'b1; addr = 32'h6000_0100; size = 2'd2;
    @(negedge clk);
    tick(); req = 1'b0; arready = 1'b1;
    @(negedge clk);
    tick(); arready = 1'b0; req = 1'b1; addr = 32'h6000_0200; r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if ({addr_ok, data_ok} !== 2'b11) begin n_fail++; $display("FAIL simul_both: got addr_ok=%b data_ok=%b, required 1,1", addr_ok, data_ok); end
    tick(); req = 1'b0; r_idle(); arready = 1'b1;
    @(negedge clk);
    tick(); arready = 1'b0; r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if (data_ok !== 1'b1) begin n_fail++; $display("FAIL simul_second: got data_ok=%b, required 1", data_ok); end
    tick(); r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if (data_ok !== 1'b0) begin n_fail++; $display("FAIL simul_cnt_kept: got data_ok=%b, required 0", data_ok); end
    tick(); r_idle();
    check_drained("simul");
  endtask

  task automatic test_write_rejected();
    tick(); req = 1'b1; wr = 1'b1; addr = 32'h7000_0000; size = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({addr_ok, arvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_reject%0d: got addr_ok=%b arvalid=%b, required 0,0", i, addr_ok, arvalid); end
      tick();
    end
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic test_stray();
    tick(); r_beat(2'b10);
    @(negedge clk);
    n_tests++;
    if ({data_ok, axi_err} !== 2'b00) begin n_fail++; $display("FAIL stray_beat: got data_ok=%b err=%b, required 0,0", data_ok, axi_err); end
    tick(); r_idle();
    @(negedge clk);
    n_tests++;
    if ({arvalid, axi_err} !== 2'b00) begin n_fail++; $display("FAIL stray_no_change: got arvalid=%b err=%b, required 0,0", arvalid, axi_err); end
  endtask

  task automatic test_error();
    tick(); req = 1'b1; addr = 32'h4000_0000; size = 2'd2;
    @(negedge clk);
    tick(); req = 1'b0; arready = 1'b1;
    @(negedge clk);
    tick(); arready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (axi_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b, required 0", axi_err); end
    tick(); r_beat(2'b10);
    @(negedge clk);
    n_tests++;
    if (data_ok !== 1'b1) begin n_fail++; $display("FAIL err_data_ok: got %b, required 1", data_ok); end
    tick(); r_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (axi_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky%0d: got %b, required 1", i, axi_err); end
      tick();
    end
    check_drained("err");
  endtask

  task automatic test_async_reset();
    tick(); req = 1'b1; addr = 32'h5000_0000; size = 2'd2; arready = 1'b0;
    @(negedge clk);
    tick(); req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got arvalid=%b, required 1", arvalid); end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({arvalid, araddr, arsize, addr_ok, axi_err} !== {1'b0, 32'd0, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL arst_immediate: got arvalid=%b araddr=%h arsize=%0d addr_ok=%b err=%b, required all 0", arvalid, araddr, arsize, addr_ok, axi_err);
    end
    #1 resetn = 1'b1;
    exp_q.delete();
    ar_exp_q.delete();
    slave_q.delete();
    tick(); r_beat(2'b00);
    @(negedge clk);
    n_tests++;
    if (data_ok !== 1'b0) begin n_fail++; $display("FAIL arst_stray: got data_ok=%b, required 0", data_ok); end
    tick(); r_idle();
    check_drained("arst");
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_sizes();
    test_backpressure();
    test_full();
    test_simultaneous();
    test_write_rejected();
    test_stray();
    test_error();
    test_async_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
